// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared types and constants for the intersection sequencer and
//             the time-parameter store (state enum, interval selects, lamps).
//  Options  : TRAFFIC_WALK_EN enables the pedestrian WALK phase decode.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Sequencer states; code 3'd7 is unused and decodes like MAIN_GRN.
  typedef enum logic [2:0] {
    MAIN_GRN     = 3'd0,
    MAIN_GRN_EXT = 3'd1,
    MAIN_YEL     = 3'd2,
    WALK         = 3'd3,
    SIDE_GRN     = 3'd4,
    SIDE_GRN_EXT = 3'd5,
    SIDE_YEL     = 3'd6
  } state_t;

  // Interval select codes understood by the time-parameter store.
  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;

  // Lamp encodings, {red, yellow, green}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Everything the sequencer drives, bundled so it can be registered as one.
  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       walk;
  } lamp_out_t;

  // Pure decode of a state into its interval select and lamp pattern.
  function automatic lamp_out_t decode_state(input state_t s);
    lamp_out_t o;
    o.sel       = SEL_BASE;
    o.main_lamp = LAMP_G;
    o.side_lamp = LAMP_R;
    o.walk      = 1'b0;
    case (s)
      MAIN_GRN_EXT: o.sel = SEL_EXT;
      MAIN_YEL: begin
        o.sel       = SEL_YEL;
        o.main_lamp = LAMP_Y;
      end
`ifdef TRAFFIC_WALK_EN
      WALK: begin
        o.sel       = SEL_EXT;
        o.main_lamp = LAMP_R;
        o.walk      = 1'b1;
      end
`endif
      SIDE_GRN: begin
        o.main_lamp = LAMP_R;
        o.side_lamp = LAMP_G;
      end
      SIDE_GRN_EXT: begin
        o.sel       = SEL_EXT;
        o.main_lamp = LAMP_R;
        o.side_lamp = LAMP_G;
      end
      SIDE_YEL: begin
        o.sel       = SEL_YEL;
        o.main_lamp = LAMP_R;
        o.side_lamp = LAMP_Y;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_fsm_interval_counter.sv
`default_nettype none
// ============================================================================
//  Module   : interval_counter
//  Purpose  : Per-state interval timer. Waits LOAD_WAIT cycles for the store
//             output to settle, loads it (0 clamps to 1), then counts 1 Hz
//             ticks down and pulses expire_o on the tick that sees 1.
//  Revision : 1.0  initial release
// ============================================================================
module interval_counter #(
  parameter int LOAD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_i,
  input  logic       hold_i,
  input  logic       tick_i,
  input  logic [3:0] time_val_i,
  output logic       expire_o
);

  localparam int WW = (LOAD_WAIT < 2) ? 1 : $clog2(LOAD_WAIT + 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(LOAD_WAIT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  logic          run_q, run_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    count_q, count_d;

  // Expiry only exists in RUN; a frozen store means a frozen timer.
  assign expire_o = run_q & tick_i & ~hold_i & (count_q == 4'd1);

  // Next-state: hold freezes all, restart re-enters LOAD, else LOAD/RUN step.
  always_comb begin
    run_d   = run_q;
    wait_d  = wait_q;
    count_d = count_q;
    if (!hold_i) begin
      if (restart_i) begin
        run_d   = 1'b0;
        wait_d  = WAIT_INIT;
        count_d = 4'd0;
      end else if (!run_q) begin
        if (wait_q <= WAIT_ONE) begin
          run_d   = 1'b1;
          count_d = (time_val_i == 4'd0) ? 4'd1 : time_val_i;
        end else begin
          wait_d = wait_q - WAIT_ONE;
        end
      end else if (tick_i && (count_q != 4'd0)) begin
        count_d = count_q - 4'd1;
      end
    end
  end

  // Timer registers with synchronous reset into LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      wait_q  <= WAIT_INIT;
      count_q <= 4'd0;
    end else begin
      run_q   <= run_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_fsm
//  Purpose  : Intersection sequencer. Selects the interval in the time store,
//             times it with interval_counter and sequences main/side/walk
//             lamps from the side-street sensor and the walk button.
//  Options  : TRAFFIC_WALK_EN - implements the WALK phase, the walk-request
//             latch and the walk lamp; otherwise walkRequest is ignored.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int LOAD_WAIT = 2
) (
  input  logic       clk,
  input  logic       globalReset,
  input  logic       oneHzEnable,
  input  logic       reprogram,
  input  logic       sensor,
  input  logic       walkRequest,
  input  logic [3:0] timeVal,
  output logic [1:0] FSMintervalSel,
  output logic [2:0] mainLight,
  output logic [2:0] sideLight,
  output logic       walk
);

  state_t    state_q, state_d;
  logic      sensor_seen_q, sensor_seen_d;
  logic      reprog_q;
  lamp_out_t out_q;

  logic w_expire;
  logic w_reprog_fall;
  logic w_restart;
  logic w_advance;
  logic w_sensor_any;
  logic w_walk_any;

  // A fall of reprogram restarts the current interval with the new value;
  // an expiry on that same cycle is discarded in favour of the restart.
  assign w_reprog_fall = reprog_q & ~reprogram;
  assign w_restart     = w_expire | w_reprog_fall;
  assign w_advance     = w_expire & ~w_reprog_fall;

  // Latch value including this cycle, so a sensor seen on the expiry cycle counts.
  assign w_sensor_any = sensor_seen_q |
                        (sensor & ((state_q == MAIN_GRN) | (state_q == SIDE_GRN)));

`ifdef TRAFFIC_WALK_EN
  logic walk_pend_q, walk_pend_d;
  assign w_walk_any = walk_pend_q | walkRequest;
`else
  logic w_unused_walk;
  assign w_walk_any    = 1'b0;
  assign w_unused_walk = walkRequest;
`endif

  interval_counter #(
    .LOAD_WAIT (LOAD_WAIT)
  ) u_interval_counter (
    .clk        (clk),
    .rst        (globalReset),
    .restart_i  (w_restart),
    .hold_i     (reprogram),
    .tick_i     (oneHzEnable),
    .time_val_i (timeVal),
    .expire_o   (w_expire)
  );

  // Next state and latch updates; transitions happen only on expiry.
  always_comb begin
    state_d       = state_q;
    sensor_seen_d = w_sensor_any;
`ifdef TRAFFIC_WALK_EN
    walk_pend_d   = w_walk_any;
`endif
    if (w_advance) begin
      case (state_q)
        MAIN_GRN_EXT: begin
          state_d       = MAIN_YEL;
          sensor_seen_d = 1'b0;
        end
        MAIN_YEL: begin
          state_d = w_walk_any ? WALK : SIDE_GRN;
`ifdef TRAFFIC_WALK_EN
          if (w_walk_any) walk_pend_d = 1'b0;
`endif
        end
`ifdef TRAFFIC_WALK_EN
        WALK: state_d = SIDE_GRN;
`endif
        SIDE_GRN: begin
          if (w_sensor_any) begin
            state_d = SIDE_GRN_EXT;
          end else begin
            state_d       = SIDE_YEL;
            sensor_seen_d = 1'b0;
          end
        end
        SIDE_GRN_EXT: begin
          state_d       = SIDE_YEL;
          sensor_seen_d = 1'b0;
        end
        SIDE_YEL: state_d = MAIN_GRN;
        default: begin
          // MAIN_GRN, plus any unused encoding, behaves as main green.
          if (w_sensor_any) begin
            state_d = MAIN_GRN_EXT;
          end else begin
            state_d       = MAIN_YEL;
            sensor_seen_d = 1'b0;
          end
        end
      endcase
    end
  end

  // State, latches and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      state_q       <= MAIN_GRN;
      sensor_seen_q <= 1'b0;
      reprog_q      <= 1'b0;
      out_q         <= decode_state(MAIN_GRN);
    end else begin
      state_q       <= state_d;
      sensor_seen_q <= sensor_seen_d;
      reprog_q      <= reprogram;
      out_q         <= decode_state(state_d);
    end
  end

`ifdef TRAFFIC_WALK_EN
  // Walk-request latch.
  always_ff @(posedge clk) begin
    if (globalReset) walk_pend_q <= 1'b0;
    else             walk_pend_q <= walk_pend_d;
  end
`endif

  assign FSMintervalSel = out_q.sel;
  assign mainLight      = out_q.main_lamp;
  assign sideLight      = out_q.side_lamp;
  assign walk           = out_q.walk;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_fsm
//  Purpose  : Directed bench for traffic_light_fsm with a registered store
//             model; state visits are table driven, reprogram and reset
//             corner cases are hand sequenced.
//  Options  : TRAFFIC_WALK_EN selects the walk-phase expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_fsm;

  localparam int LW = 2;

  logic       clk = 1'b0;
  logic       globalReset, oneHzEnable, reprogram, sensor, walkRequest;
  logic [3:0] timeVal;
  logic [1:0] FSMintervalSel;
  logic [2:0] mainLight, sideLight;
  logic       walk;

  logic [3:0] st_base, st_ext, st_yel;
  int         tick_cnt;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic       sens;
    logic       wreq;
    logic [3:0] yel;
    logic [1:0] sel;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    int         ticks;
  } vec_t;

  vec_t vq[$];

  traffic_light_fsm #(.LOAD_WAIT(LW)) dut (
    .clk            (clk),
    .globalReset    (globalReset),
    .oneHzEnable    (oneHzEnable),
    .reprogram      (reprogram),
    .sensor         (sensor),
    .walkRequest    (walkRequest),
    .timeVal        (timeVal),
    .FSMintervalSel (FSMintervalSel),
    .mainLight      (mainLight),
    .sideLight      (sideLight),
    .walk           (walk)
  );

  always #5 clk = ~clk;

  // Time-parameter store: one register stage behind the select register.
  always @(posedge clk) begin
    if (reprogram)                   timeVal <= 4'hF;
    else if (FSMintervalSel == 2'b00) timeVal <= st_base;
    else if (FSMintervalSel == 2'b01) timeVal <= st_ext;
    else if (FSMintervalSel == 2'b10) timeVal <= st_yel;
    else                              timeVal <= 4'hF;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel, input logic [2:0] ml,
                         input logic [2:0] sl, input logic wk);
    chk({tag, " sel"},  int'(FSMintervalSel), int'(sel));
    chk({tag, " main"}, int'(mainLight),      int'(ml));
    chk({tag, " side"}, int'(sideLight),      int'(sl));
    chk({tag, " walk"}, int'(walk),           int'(wk));
  endtask

  task automatic step(input logic t, input logic s, input logic w);
    oneHzEnable = t;
    sensor      = s;
    walkRequest = w;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic w, input logic [3:0] y, input logic [1:0] sel,
                     input logic [2:0] ml, input logic [2:0] sl, input logic wk, input int t);
    vec_t v;
    v.sens = s; v.wreq = w; v.yel = y; v.sel = sel;
    v.ml = ml; v.sl = sl; v.wk = wk; v.ticks = t;
    vq.push_back(v);
  endtask

  // Visit one state: check its outputs on entry, pulse inputs in its first
  // cycle, count the ticks that land after LOAD until the outputs change.
  task automatic run_vec(input vec_t v, input string tag);
    int   off, nt;
    logic t, last_t, done;
    st_yel = v.yel;
    chk_out(tag, v.sel, v.ml, v.sl, v.wk);
    off = 0; nt = 0; done = 1'b0; last_t = 1'b0;
    while (!done && off < 200) begin
      t = (tick_cnt == 3);
      tick_cnt = (tick_cnt + 1) % 4;
      step(t, v.sens && off == 0, v.wreq && off == 0);
      if (t && off >= LW) nt++;
      last_t = t;
      off++;
      if ({FSMintervalSel, mainLight, sideLight, walk} != {v.sel, v.ml, v.sl, v.wk})
        done = 1'b1;
    end
    chk({tag, " left state in budget"}, int'(done), 1);
    chk({tag, " ticks"}, nt, v.ticks);
    chk({tag, " change on tick edge"}, int'(last_t), 1);
  endtask

  function automatic vec_t mk(input logic s, input logic w, input logic [3:0] y,
                              input logic [1:0] sel, input logic [2:0] ml,
                              input logic [2:0] sl, input logic wk, input int t);
    vec_t v;
    v.sens = s; v.wreq = w; v.yel = y; v.sel = sel;
    v.ml = ml; v.sl = sl; v.wk = wk; v.ticks = t;
    return v;
  endfunction

  initial begin
    // Basic cycle, no sensor, no walk.
    add(0, 0, 3, 2'b00, 3'b001, 3'b100, 0, 1);
    add(0, 0, 3, 2'b10, 3'b010, 3'b100, 0, 3);
    add(0, 0, 3, 2'b00, 3'b100, 3'b001, 0, 1);
    add(0, 0, 3, 2'b10, 3'b100, 3'b010, 0, 3);
    // Sensor pulse in MAIN_GRN extends once; SIDE_GRN is not extended.
    add(1, 0, 3, 2'b00, 3'b001, 3'b100, 0, 1);
    add(0, 0, 3, 2'b01, 3'b001, 3'b100, 0, 2);
    add(0, 0, 3, 2'b10, 3'b010, 3'b100, 0, 3);
    add(0, 0, 3, 2'b00, 3'b100, 3'b001, 0, 1);
    add(0, 1, 3, 2'b10, 3'b100, 3'b010, 0, 3);  // walk request in SIDE_YEL
    add(0, 0, 3, 2'b00, 3'b001, 3'b100, 0, 1);
    add(0, 0, 3, 2'b10, 3'b010, 3'b100, 0, 3);
`ifdef TRAFFIC_WALK_EN
    add(0, 0, 3, 2'b01, 3'b100, 3'b100, 1, 2);  // WALK
`endif
    add(0, 0, 3, 2'b00, 3'b100, 3'b001, 0, 1);
    add(0, 0, 3, 2'b10, 3'b100, 3'b010, 0, 3);
    // Yellow interval of 0 clamps to one tick; walk latch must be clear.
    add(0, 0, 0, 2'b00, 3'b001, 3'b100, 0, 1);
    add(0, 0, 0, 2'b10, 3'b010, 3'b100, 0, 1);
    add(0, 0, 3, 2'b00, 3'b100, 3'b001, 0, 1);
    add(0, 0, 3, 2'b10, 3'b100, 3'b010, 0, 3);

    globalReset = 1'b1; reprogram = 1'b0; sensor = 1'b0;
    walkRequest = 1'b0; oneHzEnable = 1'b0;
    st_base = 4'd1; st_ext = 4'd2; st_yel = 4'd3; tick_cnt = 0;
    repeat (3) step(0, 0, 0);
    globalReset = 1'b0;

    foreach (vq[i]) run_vec(vq[i], $sformatf("v%0d", i));

    // Reprogram mid-SIDE_GRN: rise coincides with a tick, fall with a tick.
    run_vec(mk(0, 0, 3, 2'b00, 3'b001, 3'b100, 0, 1), "rp main_grn");
    run_vec(mk(0, 0, 3, 2'b10, 3'b010, 3'b100, 0, 3), "rp main_yel");
    chk_out("rp side_grn entry", 2'b00, 3'b100, 3'b001, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    reprogram = 1'b1;
    st_base   = 4'd5;
    for (int i = 0; i < 10; i++) begin
      step(i % 2 == 0, 0, 0);
      chk($sformatf("rp frozen c%0d", i), int'({FSMintervalSel, mainLight, sideLight, walk}),
          int'({2'b00, 3'b100, 3'b001, 1'b0}));
    end
    reprogram = 1'b0;
    step(1, 0, 0);
    chk("rp fall no expiry", int'({FSMintervalSel, mainLight, sideLight}),
        int'({2'b00, 3'b100, 3'b001}));
    tick_cnt = 0;
    run_vec(mk(0, 0, 3, 2'b00, 3'b100, 3'b001, 0, 5), "rp side_grn 5");
    st_base = 4'd1;
    run_vec(mk(0, 1, 3, 2'b10, 3'b100, 3'b010, 0, 3), "rs side_yel");

    // Mid-interval reset with latches set; they must not survive it.
    run_vec(mk(1, 0, 3, 2'b00, 3'b001, 3'b100, 0, 1), "rs main_grn");
`ifdef TRAFFIC_WALK_EN
    run_vec(mk(0, 0, 3, 2'b01, 3'b001, 3'b100, 0, 2), "rs main_ext");
    run_vec(mk(0, 0, 3, 2'b10, 3'b010, 3'b100, 0, 3), "rs main_yel");
    chk_out("rs walk entry", 2'b01, 3'b100, 3'b100, 1);
    step(0, 0, 1);
`else
    chk_out("rs ext entry", 2'b01, 3'b001, 3'b100, 0);
    step(0, 0, 1);
`endif
    step(0, 0, 0);
    globalReset = 1'b1;
    step(1, 0, 0);
    globalReset = 1'b0;
    tick_cnt = 0;
    run_vec(mk(0, 0, 3, 2'b00, 3'b001, 3'b100, 0, 1), "ar main_grn");
    run_vec(mk(0, 0, 3, 2'b10, 3'b010, 3'b100, 0, 3), "ar main_yel");
    run_vec(mk(0, 0, 3, 2'b00, 3'b100, 3'b001, 0, 1), "ar side_grn");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
